uart8_tx_fifo: RTL
==================

UART8_TX_FIFO -- requirements
Module: uart8_tx_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, meaning the FIFO entry count; it must be a power of two and at least 2.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-003 SHALL provide port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port: en  input  1  launch enable; 0 blocks new byte launches but does not block pushes.
REQ-006 SHALL provide port: wrEn  input  1  push strobe, one byte per cycle.
REQ-007 SHALL provide port: wrData  input  8  byte to push.
REQ-008 SHALL provide port: full  output  1  FIFO holds DEPTH bytes.
REQ-009 SHALL provide port: empty  output  1  FIFO holds 0 bytes.
REQ-010 SHALL provide port: count  output  $clog2(DEPTH)+1  number of stored bytes.
REQ-011 SHALL provide port: overflow  output  1  one-cycle pulse when a push is rejected.
REQ-012 SHALL provide port: txStart  output  1  start request to the Uart8 transmitter.
REQ-013 SHALL provide port: txByte  output  8  byte to the Uart8 in port.
REQ-014 SHALL provide port: txBusy  input  1  Uart8 transmitter busy.
REQ-015 SHALL provide port: busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL accept a push at an edge iff wrEn=1 and full=0 at that edge; the push decision does not depend on a pop in the same cycle.
REQ-017 SHALL pulse overflow high for exactly the cycle after an edge with wrEn=1 and full=1, and SHALL leave FIFO contents unchanged on that push.
REQ-018 SHALL update count at each edge as +1 (push only), -1 (pop only), or unchanged (push and pop together, or neither).
REQ-019 SHALL compute full and empty from count, and SHALL wrap read and write pointers modulo DEPTH.
REQ-020 SHALL implement the launch FSM with states IDLE, START and SEND.
REQ-021 In IDLE, if en=1, empty=0 and txBusy=0, SHALL at that edge pop the head byte into txByte, set txStart=1 and go to START; otherwise SHALL stay in IDLE.
REQ-022 In START, SHALL hold txStart=1 and txByte stable until txBusy=1 is sampled, then SHALL clear txStart and go to SEND.
REQ-023 In SEND, SHALL go to IDLE when txBusy=0 is sampled.
REQ-024 SHALL let a back-to-back launch occur at the earliest in the cycle after re-entering IDLE.
REQ-025 SHALL keep txByte unchanged outside IDLE launches, so it holds the last launched byte.
REQ-026 Launch latency: for a push at edge E into an empty FIFO with en=1 and txBusy=0, SHALL have txStart=1 and txByte valid after edge E+1.
REQ-027 SHALL sample en only in IDLE; deasserting en in START or SEND SHALL NOT abort the byte in flight.
REQ-028 SHALL emit bytes in push order, with no loss or duplication.

Reset
REQ-029 While reset=1 at an edge, SHALL clear count, both pointers, overflow and txStart to 0, set txByte=8'h00, set state to IDLE, and force empty=1, full=0, busy=0.
REQ-030 SHALL give reset priority over a simultaneous push or launch; bytes stored before reset are discarded.
REQ-031 On reset during START or SEND, SHALL NOT start a new launch until txBusy=0 is sampled in IDLE, because a Uart8 frame may still be in progress.

Verification
REQ-032 Scenario: reset, en=1, push 8'b10001010 at edge E, txBusy=0 -> txStart=1 and txByte=8'b10001010 after E+1; model raises txBusy -> txStart=0 next cycle; txBusy falls -> busy=0, empty=1.
REQ-033 Scenario: en=0, push 8'b01111010 -> no txStart and count=1; raise en -> txStart after the next edge with txByte=8'b01111010.
REQ-034 Scenario: push 17 bytes 0x00..0x10 on consecutive cycles with en=0 (DEPTH=16) -> full=1 after the 16th push; overflow pulses once on the 17th; count=16; after en=1 the Uart8 model receives 0x00..0x0F in order.
REQ-035 Scenario: count=3 and state IDLE, launch and push at the same edge -> count stays 3.
REQ-036 Scenario: assert reset while in SEND with txBusy=1 and count=5 -> count=0, txStart=0; a new push is not launched until txBusy=0.
REQ-037 Scenario: hold txBusy=0 for 20 cycles after a launch -> txStart stays 1 with txByte stable throughout.

Source files
------------

// File: rtl/uart8_tx_fifo_if.sv
// rtl/uart8_tx_fifo_if.sv - push, status and Uart8 launch signals of the byte FIFO
interface uart8_tx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          en;
    logic          wrEn;
    logic [7:0]    wrData;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          txStart;
    logic [7:0]    txByte;
    logic          txBusy;
    logic          busy;

    // Producer / Uart8 side
    modport master (
        output en, wrEn, wrData, txBusy,
        input  full, empty, count, overflow, txStart, txByte, busy
    );

    // FIFO side
    modport slave (
        input  en, wrEn, wrData, txBusy,
        output full, empty, count, overflow, txStart, txByte, busy
    );
endinterface

// File: rtl/uart8_tx_fifo.sv
// rtl/uart8_tx_fifo.sv - byte FIFO feeding a Uart8 transmitter through a start/busy handshake
module uart8_tx_fifo #(
    parameter int DEPTH = 16    // power of two, at least 2
) (
    input  logic           clk,
    input  logic           reset,
    uart8_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic [7:0]    mem_q [DEPTH];

    logic full_w;
    logic empty_w;
    logic push;
    logic pop;

    assign full_w       = (count_q == CW'(DEPTH));
    assign empty_w      = (count_q == '0);

    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.txStart  = tx_start_q;
    assign bus.txByte   = tx_byte_q;
    assign bus.busy     = (state_q != IDLE);

    // Pointer/count bookkeeping; a push never looks at a same-cycle pop, so a full FIFO rejects it
    always_comb begin
        push       = bus.wrEn && !full_w;
        // Launch only from IDLE; txBusy must be low there, which also covers a frame left running across reset
        pop        = (state_q == IDLE) && bus.en && !empty_w && !bus.txBusy;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        overflow_d = bus.wrEn && full_w;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Launch FSM: IDLE pops and raises txStart, START holds it until txBusy, SEND waits for the frame to end
    always_comb begin
        state_d    = state_q;
        tx_start_d = tx_start_q;
        tx_byte_d  = tx_byte_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d    = START;
                    tx_start_d = 1'b1;
                    tx_byte_d  = mem_q[rd_ptr_q];
                end
            end
            START: begin
                if (bus.txBusy) begin
                    state_d    = SEND;
                    tx_start_d = 1'b0;
                end
            end
            SEND: begin
                if (!bus.txBusy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_start_d = 1'b0;
            end
        endcase
    end

    // State registers with reset taking priority over push and launch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    // Byte storage; contents need no reset because the pointers and count define validity
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= bus.wrData;
        end
    end
endmodule
